// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the Ludi-V fetch program-counter logic:
//   - pc_state_e      : PC generator state encodings (2-bit)
//   - redirect_kind_e : which source produced the next-PC target
//   - is_checked_redirect() : true for redirects that are alignment-checked
//                             and that can be captured into the pending slot
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_BOOT  = 2'd0,
        PC_RUN   = 2'd1,
        PC_HOLD  = 2'd2,
        PC_FAULT = 2'd3
    } pc_state_e;

    typedef enum logic [2:0] {
        KIND_SEQ  = 3'd0,
        KIND_BR   = 3'd1,
        KIND_JAL  = 3'd2,
        KIND_JALR = 3'd3,
        KIND_TRAP = 3'd4
    } redirect_kind_e;

    // BR/JAL/JALR are the instruction-driven redirects; traps and the
    // sequential step are never misaligned and are never parked in pending.
    function automatic logic is_checked_redirect(input redirect_kind_e kind);
        return (kind == KIND_BR) || (kind == KIND_JAL) || (kind == KIND_JALR);
    endfunction

endpackage

// File: rtl/pc_gen_target.sv
// -----------------------------------------------------------------------------
// pc_gen_target (module pc_target)
// Combinational next-PC selection for the fetch PC generator.
// Priority: trap > jalr > jal > taken branch > sequential.
// Ports:
//   pc           in   XLEN  current fetch address
//   branch/cond  in   1     conditional branch present / condition true
//   jal, jalr    in   1     unconditional jump kinds
//   imm          in   XLEN  sign-extended immediate
//   reg_base     in   XLEN  rs1 value for JALR
//   trap         in   1     trap redirect request
//   trap_vector  in   XLEN  trap handler address
//   target       out  XLEN  selected next PC (wraps modulo 2^XLEN)
//   kind         out  3     redirect_kind_e of the selected source
//   misaligned   out  1     target violates IALIGN (BR/JAL/JALR only)
// -----------------------------------------------------------------------------
module pc_target
    import pc_gen_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int IALIGN = 32,
    parameter int STEP   = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    input  logic            cond,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] reg_base,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] target,
    output redirect_kind_e  kind,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
    // 16-bit alignment only requires bit 0 clear; 32-bit requires bits [1:0].
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = reg_base + imm;

    always_comb begin
        target = pc + STEP_X;
        kind   = KIND_SEQ;
        if (trap) begin
            target = {trap_vector[XLEN-1:2], 2'b00};
            kind   = KIND_TRAP;
        end else if (jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
            kind   = KIND_JALR;
        end else if (jal) begin
            target = pc + imm;
            kind   = KIND_JAL;
        end else if (branch && cond) begin
            target = pc + imm;
            kind   = KIND_BR;
        end
    end

    assign misaligned = is_checked_redirect(kind) && ((target & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the Ludi-V fetch stage. Issues fetch
// addresses, follows branch/JAL/JALR/trap redirects with one cycle of latency,
// parks a redirect that arrives while fetch is stalled, and freezes with a
// fault report when an instruction redirect target is misaligned.
// Ports:
//   i_Clock, i_Reset         clock / synchronous active-high reset
//   i_Ready                  fetch accepts o_PC this cycle
//   i_Branch, i_Cond         conditional branch and its outcome
//   i_Jal, i_Jalr            jump requests
//   i_Immediate, i_RegBase   target operands
//   i_Trap, i_TrapVector     trap redirect request and handler address
//   o_PC, o_Valid            fetch address and its valid flag (registered)
//   o_RetAddr                o_PC + STEP (combinational link value)
//   o_Misaligned, o_BadAddr  fault flag and offending target (registered)
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32,
    parameter int              STEP         = 4
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Ready,
    input  logic            i_Branch,
    input  logic            i_Cond,
    input  logic            i_Jal,
    input  logic            i_Jalr,
    input  logic [XLEN-1:0] i_Immediate,
    input  logic [XLEN-1:0] i_RegBase,
    input  logic            i_Trap,
    input  logic [XLEN-1:0] i_TrapVector,
    output logic [XLEN-1:0] o_PC,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_RetAddr,
    output logic            o_Misaligned,
    output logic [XLEN-1:0] o_BadAddr
);

    localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] target;
    redirect_kind_e  kind;
    logic            target_misaligned;

    pc_target #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN),
        .STEP   (STEP)
    ) u_target (
        .pc          (pc_q),
        .branch      (i_Branch),
        .cond        (i_Cond),
        .jal         (i_Jal),
        .jalr        (i_Jalr),
        .imm         (i_Immediate),
        .reg_base    (i_RegBase),
        .trap        (i_Trap),
        .trap_vector (i_TrapVector),
        .target      (target),
        .kind        (kind),
        .misaligned  (target_misaligned)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= PC_BOOT;
            pc_q      <= RESET_VECTOR;
            pending_q <= '0;
            bad_q     <= '0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            bad_q     <= bad_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        bad_d     = bad_q;

        if (i_Trap) begin
            // A trap wins from every state and ignores back-pressure.
            pc_d      = target;
            pending_d = '0;
            bad_d     = '0;
            state_d   = PC_RUN;
        end else begin
            unique case (state_q)
                PC_BOOT: state_d = PC_RUN;
                PC_RUN: begin
                    if (target_misaligned) begin
                        // Fault is raised whether or not fetch is ready: a bad
                        // target must never reach o_PC or the pending slot.
                        state_d = PC_FAULT;
                        bad_d   = target;
                    end else if (i_Ready) begin
                        pc_d = target;
                    end else if (is_checked_redirect(kind)) begin
                        pending_d = target;
                        state_d   = PC_HOLD;
                    end
                end
                PC_HOLD: begin
                    // Redirect inputs are repeats of the same instruction here.
                    if (i_Ready) begin
                        pc_d      = pending_q;
                        pending_d = '0;
                        state_d   = PC_RUN;
                    end
                end
                PC_FAULT: ;
                default: state_d = PC_BOOT;
            endcase
        end

        valid_d = (state_d == PC_RUN) || (state_d == PC_HOLD);
        mis_d   = (state_d == PC_FAULT);
    end

    assign o_PC         = pc_q;
    assign o_Valid      = valid_q;
    assign o_Misaligned = mis_q;
    assign o_BadAddr    = bad_q;
    assign o_RetAddr    = pc_q + STEP_X;

endmodule
